// File: rtl/mem_arbiter_l1_if.sv
// rtl/mem_arbiter_l1_if.sv - L1 icache/dcache miss ports and the shared line-fill memory port
interface mem_arbiter_l1_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_req;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_data;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_data;
    logic              d_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;

    modport slave (
        input  i_req, i_address, d_req, d_we, d_address, d_wdata, mem_rdata, mem_ready,
        output i_data, i_valid, d_data, d_valid, mem_req, mem_we, mem_address, mem_wdata, busy
    );

    modport master (
        output i_req, i_address, d_req, d_we, d_address, d_wdata, mem_rdata, mem_ready,
        input  i_data, i_valid, d_data, d_valid, mem_req, mem_we, mem_address, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter_l1.sv
// rtl/mem_arbiter_l1.sv - round-robin arbiter of L1 I/D misses onto one line-fill port
// Optional: define ARB_FIXED_PRIO_EN to always favour the dcache on a tie.
module mem_arbiter_l1 #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    mem_arbiter_l1_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;
    logic              r_owner_d;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_address;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_i_data;
    logic [LINE_W-1:0] r_d_data;
    logic              r_i_valid;
    logic              r_d_valid;
    logic              w_grant;
    logic              w_grant_d;
    logic              w_grant_wr;
    logic [ADDR_W-1:0] w_addr;

    always_comb begin
        w_grant = bus.i_req | bus.d_req;
`ifdef ARB_FIXED_PRIO_EN
        w_grant_d = bus.d_req;
`else
        // On a tie the side that did not win last time gets the port.
        w_grant_d = bus.d_req & (~bus.i_req | ~r_last_d);
`endif
        w_grant_wr = w_grant_d & bus.d_we;
        w_addr     = (w_grant_d ? bus.d_address : bus.i_address) & LINE_MASK;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_next = ST_ISSUE;
            ST_ISSUE: if (bus.mem_ready) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_last_d      <= 1'b0;
            r_owner_d     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_i_data      <= '0;
            r_d_data      <= '0;
            r_i_valid     <= 1'b0;
            r_d_valid     <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            if (r_state == ST_IDLE && w_grant) begin
                r_owner_d     <= w_grant_d;
                r_last_d      <= w_grant_d;
                r_mem_req     <= 1'b1;
                r_mem_we      <= w_grant_wr;
                r_mem_address <= w_addr;
                r_mem_wdata   <= w_grant_wr ? bus.d_wdata : '0;
            end else if (r_state == ST_ISSUE && bus.mem_ready) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_owner_d) begin
                    r_d_valid <= 1'b1;
                    // A write-back only gets an acknowledge; d_data keeps the last fill.
                    if (!r_mem_we) r_d_data <= bus.mem_rdata;
                end else begin
                    r_i_valid <= 1'b1;
                    r_i_data  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.i_data      = r_i_data;
    assign bus.d_data      = r_d_data;
    assign bus.i_valid     = r_i_valid;
    assign bus.d_valid     = r_d_valid;
    assign bus.busy        = (r_state != ST_IDLE);
endmodule
